// File: rtl/plca_pkg.sv
// plca_pkg
//   Definitions shared by the PLCA command codec and the PLCA control state
//   machine: command codes exchanged between them, receive FSM state
//   encodings and the default MII nibbles that signal BEACON and COMMIT.
//   No ports; imported with "import plca_pkg::*".
package plca_pkg;

    // Command codes on tx_cmd / rx_cmd. Code 2'b11 is never produced and is
    // treated as CMD_NONE wherever it is received.
    localparam logic [1:0] CMD_BEACON = 2'b00;
    localparam logic [1:0] CMD_COMMIT = 2'b01;
    localparam logic [1:0] CMD_NONE   = 2'b10;

    // Receive FSM states; the encoding is visible on the rx_state debug port.
    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_BEACON = 2'd1,
        R_COMMIT = 2'd2,
        R_DATA   = 2'd3
    } rx_state_e;

    // TXD/RXD nibbles that carry a command while ER=1 and EN/DV=0.
    localparam logic [3:0] DEFAULT_BEACON_NIBBLE = 4'b0010;
    localparam logic [3:0] DEFAULT_COMMIT_NIBBLE = 4'b0011;

    localparam logic [15:0] BEACON_CNT_MAX = 16'hFFFF;

    // Command reported to the control machine while the receive FSM sits in
    // a given state.
    function automatic logic [1:0] stateToCmd(input rx_state_e state);
        case (state)
            R_BEACON: stateToCmd = CMD_BEACON;
            R_COMMIT: stateToCmd = CMD_COMMIT;
            default:  stateToCmd = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/plca_rx_cmd_det.sv
// plca_rx_cmd_det
//   Receive side of the PLCA command codec: classifies each MII receive
//   sample as frame data, BEACON, COMMIT or nothing, reports the result to
//   the control machine and counts BEACON arrivals (saturating).
//   Optional macro PLCA_RX_CMD_PERSIST_EN: a BEACON/COMMIT pattern must be
//   sampled on two consecutive edges before it is reported.
//
//   Ports:
//     clk, reset_n   MII clock, asynchronous active-low reset
//     plcaEn_i       0 forces the FSM idle and freezes the counter
//     rxDv_i/rxEr_i  receive strobes from the PHY
//     rxd_i          receive nibble from the PHY
//     rxCmd_o        decoded command (BEACON/COMMIT/NONE)
//     receiving_o    frame reception in progress
//     rxState_o      current FSM state (debug)
//     beaconCnt_o    saturating count of BEACON entries
module plca_rx_cmd_det
    import plca_pkg::*;
#(
    parameter logic [3:0] BEACON_NIBBLE = DEFAULT_BEACON_NIBBLE,
    parameter logic [3:0] COMMIT_NIBBLE = DEFAULT_COMMIT_NIBBLE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        plcaEn_i,
    input  logic        rxDv_i,
    input  logic        rxEr_i,
    input  logic [3:0]  rxd_i,
    output logic [1:0]  rxCmd_o,
    output logic        receiving_o,
    output logic [1:0]  rxState_o,
    output logic [15:0] beaconCnt_o
);

    rx_state_e   state_q, state_d;
    logic [15:0] beaconCnt_q, beaconCnt_d;
    logic        receiving_q;

`ifdef PLCA_RX_CMD_PERSIST_EN
    // pending_q: a command pattern was sampled on the previous edge;
    // lastCommit_q: that pattern was COMMIT (0 = BEACON).
    logic pending_q, pending_d;
    logic lastCommit_q, lastCommit_d;
`endif

    // Next-state decode in priority order (data, BEACON, COMMIT, idle),
    // plus the counter, which only advances on entry into R_BEACON so a
    // persisting BEACON pattern counts once.
    always_comb begin
        state_d     = R_IDLE;
        beaconCnt_d = beaconCnt_q;
`ifdef PLCA_RX_CMD_PERSIST_EN
        pending_d    = 1'b0;
        lastCommit_d = lastCommit_q;
`endif
        if (plcaEn_i) begin
            if (rxDv_i) begin
                state_d = R_DATA;
            end else if (rxEr_i && (rxd_i == BEACON_NIBBLE)) begin
`ifdef PLCA_RX_CMD_PERSIST_EN
                pending_d    = 1'b1;
                lastCommit_d = 1'b0;
                if (pending_q && !lastCommit_q) begin
                    state_d = R_BEACON;
                end
`else
                state_d = R_BEACON;
`endif
            end else if (rxEr_i && (rxd_i == COMMIT_NIBBLE)) begin
`ifdef PLCA_RX_CMD_PERSIST_EN
                pending_d    = 1'b1;
                lastCommit_d = 1'b1;
                if (pending_q && lastCommit_q) begin
                    state_d = R_COMMIT;
                end
`else
                state_d = R_COMMIT;
`endif
            end
        end
        if ((state_d == R_BEACON) && (state_q != R_BEACON) &&
            (beaconCnt_q != BEACON_CNT_MAX)) begin
            beaconCnt_d = beaconCnt_q + 16'd1;
        end
    end

    // State, counter and qualifier registers. receiving is simply the
    // registered RX_DV: with PLCA enabled RX_DV=1 always selects R_DATA,
    // and with PLCA disabled the raw registered strobe is what is wanted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= R_IDLE;
            beaconCnt_q <= 16'd0;
            receiving_q <= 1'b0;
`ifdef PLCA_RX_CMD_PERSIST_EN
            pending_q    <= 1'b0;
            lastCommit_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beaconCnt_q <= beaconCnt_d;
            receiving_q <= rxDv_i;
`ifdef PLCA_RX_CMD_PERSIST_EN
            pending_q    <= pending_d;
            lastCommit_q <= lastCommit_d;
`endif
        end
    end

    assign rxCmd_o     = stateToCmd(state_q);
    assign receiving_o = receiving_q;
    assign rxState_o   = state_q;
    assign beaconCnt_o = beaconCnt_q;

endmodule

// File: rtl/plca_cmd_codec.sv
// plca_cmd_codec
//   MII-side command codec of the PLCA reconciliation sublayer. Transmit:
//   MAC frames pass through untouched; when the MAC is idle the control
//   machine's BEACON/COMMIT command is encoded as ER=1 plus a command nibble.
//   Receive: BEACON/COMMIT patterns and frame activity are decoded by
//   plca_rx_cmd_det. Optional macro PLCA_RX_CMD_PERSIST_EN (see sub-module).
//
//   Ports:
//     clk, reset_n              MII clock, asynchronous active-low reset
//     plca_en                   0 = transparent mode
//     tx_cmd                    command from the control machine
//     mac_tx_en/_er, mac_txd    MAC transmit interface
//     TX_EN, TX_ER, TXD         registered transmit interface to the PHY
//     RX_DV, RX_ER, RXD         receive interface from the PHY
//     rx_cmd, receiving         decoded receive status to the control machine
//     rx_state                  receive FSM state (debug)
//     beacon_cnt                saturating count of received BEACONs
module plca_cmd_codec
    import plca_pkg::*;
#(
    parameter logic [3:0] BEACON_NIBBLE = DEFAULT_BEACON_NIBBLE,
    parameter logic [3:0] COMMIT_NIBBLE = DEFAULT_COMMIT_NIBBLE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        plca_en,
    input  logic [1:0]  tx_cmd,
    input  logic        mac_tx_en,
    input  logic        mac_tx_er,
    input  logic [3:0]  mac_txd,
    output logic        TX_EN,
    output logic        TX_ER,
    output logic [3:0]  TXD,
    input  logic        RX_DV,
    input  logic        RX_ER,
    input  logic [3:0]  RXD,
    output logic [1:0]  rx_cmd,
    output logic        receiving,
    output logic [1:0]  rx_state,
    output logic [15:0] beacon_cnt
);

    logic       txEn_q, txEn_d;
    logic       txEr_q, txEr_d;
    logic [3:0] txd_q, txd_d;

    // Transmit selection. The whole {EN, ER, TXD} vector comes from one
    // source per cycle, so MAC data and command nibbles can never mix.
    always_comb begin
        txEn_d = 1'b0;
        txEr_d = 1'b0;
        txd_d  = 4'd0;
        if (!plca_en || mac_tx_en) begin
            txEn_d = mac_tx_en;
            txEr_d = mac_tx_er;
            txd_d  = mac_txd;
        end else if (tx_cmd == CMD_BEACON) begin
            txEr_d = 1'b1;
            txd_d  = BEACON_NIBBLE;
        end else if (tx_cmd == CMD_COMMIT) begin
            txEr_d = 1'b1;
            txd_d  = COMMIT_NIBBLE;
        end
    end

    // One-cycle transmit register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txEn_q <= 1'b0;
            txEr_q <= 1'b0;
            txd_q  <= 4'd0;
        end else begin
            txEn_q <= txEn_d;
            txEr_q <= txEr_d;
            txd_q  <= txd_d;
        end
    end

    assign TX_EN = txEn_q;
    assign TX_ER = txEr_q;
    assign TXD   = txd_q;

    plca_rx_cmd_det #(
        .BEACON_NIBBLE(BEACON_NIBBLE),
        .COMMIT_NIBBLE(COMMIT_NIBBLE)
    ) u_det (
        .clk         (clk),
        .reset_n     (reset_n),
        .plcaEn_i    (plca_en),
        .rxDv_i      (RX_DV),
        .rxEr_i      (RX_ER),
        .rxd_i       (RXD),
        .rxCmd_o     (rx_cmd),
        .receiving_o (receiving),
        .rxState_o   (rx_state),
        .beaconCnt_o (beacon_cnt)
    );

endmodule

// File: tb/tb_plca_cmd_codec.sv
// tb_plca_cmd_codec
//   Self-checking bench for plca_cmd_codec: directed sequences followed by
//   randomized traffic, all compared against a cycle-level behavioural model.
//   Honours PLCA_RX_CMD_PERSIST_EN when the macro is defined.
module tb_plca_cmd_codec;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        plca_en = 1'b1;
    logic [1:0]  tx_cmd = 2'b10;
    logic        mac_tx_en = 1'b0;
    logic        mac_tx_er = 1'b0;
    logic [3:0]  mac_txd = 4'd0;
    logic        TX_EN, TX_ER;
    logic [3:0]  TXD;
    logic        RX_DV = 1'b0;
    logic        RX_ER = 1'b0;
    logic [3:0]  RXD = 4'd0;
    logic [1:0]  rx_cmd;
    logic        receiving;
    logic [1:0]  rx_state;
    logic [15:0] beacon_cnt;

    int checks = 0;
    int failures = 0;

    // Model state: expected outputs after the most recent edge.
    int          mState = 0;
    int          mPrevCls = 0;
    int          mCnt = 0;
    logic        mRecv = 1'b0;
    logic        mTxEn = 1'b0;
    logic        mTxEr = 1'b0;
    logic [3:0]  mTxd = 4'd0;

`ifdef PLCA_RX_CMD_PERSIST_EN
    localparam bit PERSIST = 1'b1;
`else
    localparam bit PERSIST = 1'b0;
`endif

    plca_cmd_codec dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .plca_en    (plca_en),
        .tx_cmd     (tx_cmd),
        .mac_tx_en  (mac_tx_en),
        .mac_tx_er  (mac_tx_er),
        .mac_txd    (mac_txd),
        .TX_EN      (TX_EN),
        .TX_ER      (TX_ER),
        .TXD        (TXD),
        .RX_DV      (RX_DV),
        .RX_ER      (RX_ER),
        .RXD        (RXD),
        .rx_cmd     (rx_cmd),
        .receiving  (receiving),
        .rx_state   (rx_state),
        .beacon_cnt (beacon_cnt)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] expCmd(input int st);
        if (st == 1) return 2'b00;
        if (st == 2) return 2'b01;
        return 2'b10;
    endfunction

    task automatic checkAll();
        checkOutput("TX_EN", 16'(TX_EN), 16'(mTxEn));
        checkOutput("TX_ER", 16'(TX_ER), 16'(mTxEr));
        checkOutput("TXD", 16'(TXD), 16'(mTxd));
        checkOutput("rx_cmd", 16'(rx_cmd), 16'(expCmd(mState)));
        checkOutput("receiving", 16'(receiving), 16'(mRecv));
        checkOutput("rx_state", 16'(rx_state), 16'(mState));
        checkOutput("beacon_cnt", beacon_cnt, 16'(mCnt));
    endtask

    task automatic modelReset();
        mState = 0; mPrevCls = 0; mCnt = 0; mRecv = 1'b0;
        mTxEn = 1'b0; mTxEr = 1'b0; mTxd = 4'd0;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then check.
    task automatic applyStimulus(input logic en, input logic [1:0] cmd,
                                 input logic mEn, input logic mEr, input logic [3:0] mD,
                                 input logic dv, input logic er, input logic [3:0] d);
        int cls;
        int nxt;
        plca_en = en; tx_cmd = cmd;
        mac_tx_en = mEn; mac_tx_er = mEr; mac_txd = mD;
        RX_DV = dv; RX_ER = er; RXD = d;
        @(posedge clk);
        // Sample classification: 3 data, 1 beacon, 2 commit, 0 nothing.
        if (dv) cls = 3;
        else if (er && d == 4'b0010) cls = 1;
        else if (er && d == 4'b0011) cls = 2;
        else cls = 0;
        if (!en || cls == 0) nxt = 0;
        else if (cls == 3) nxt = 3;
        else if (PERSIST && mPrevCls != cls) nxt = 0;
        else nxt = cls;
        if (nxt == 1 && mState != 1 && mCnt < 65535) mCnt++;
        mPrevCls = en ? cls : 0;
        mState = nxt;
        mRecv = dv;
        if (!en || mEn) begin
            mTxEn = mEn; mTxEr = mEr; mTxd = mD;
        end else if (cmd == 2'b00) begin
            mTxEn = 1'b0; mTxEr = 1'b1; mTxd = 4'b0010;
        end else if (cmd == 2'b01) begin
            mTxEn = 1'b0; mTxEr = 1'b1; mTxd = 4'b0011;
        end else begin
            mTxEn = 1'b0; mTxEr = 1'b0; mTxd = 4'd0;
        end
        #1;
        checkAll();
    endtask

    // Shorthands for common receive patterns with idle MAC.
    task automatic rxCycle(input logic dv, input logic er, input logic [3:0] d);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 4'd0, dv, er, d);
    endtask

    initial begin
        int cntSave;
        logic [3:0] nib;
        int pick;

        // Reset held with BEACON requested: everything at reset values.
        tx_cmd = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        reset_n = 1'b1;

        // BEACON encoded from the first edge after release.
        repeat (2) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        // COMMIT for 3 cycles, then MAC frame takes over.
        repeat (3) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        repeat (3) applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 4'd0);

        // BEACON x4, frame x10, BEACON x2: two counted beacons.
        cntSave = mCnt;
        repeat (4) rxCycle(1'b0, 1'b1, 4'b0010);
        repeat (10) rxCycle(1'b1, 1'b0, 4'hA);
        repeat (2) rxCycle(1'b0, 1'b1, 4'b0010);
        checkOutput("beacon_delta", beacon_cnt, 16'(cntSave + 2));
        rxCycle(1'b0, 1'b0, 4'd0);

        // COMMIT patterns of length 1 and 3 (qualification under persistence).
        rxCycle(1'b0, 1'b1, 4'b0011);
        rxCycle(1'b0, 1'b0, 4'd0);
        repeat (3) rxCycle(1'b0, 1'b1, 4'b0011);
        rxCycle(1'b0, 1'b0, 4'd0);
        // Pattern change BEACON -> COMMIT restarts qualification.
        rxCycle(1'b0, 1'b1, 4'b0010);
        repeat (2) rxCycle(1'b0, 1'b1, 4'b0011);
        rxCycle(1'b0, 1'b0, 4'd0);

        // Transparent mode: no decode, counter frozen, TX mirrors MAC.
        cntSave = mCnt;
        repeat (4) applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 4'b0010);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 4'hC, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0);
        checkOutput("beacon_frozen", beacon_cnt, 16'(cntSave));

        // Asynchronous reset mid-operation, between clock edges.
        repeat (2) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        #1 reset_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            pick = $urandom_range(0, 9);
            nib = 4'($urandom);
            if (pick < 3) nib = 4'b0010;
            else if (pick < 5) nib = 4'b0011;
            applyStimulus(($urandom_range(0, 9) != 0), 2'($urandom),
                          ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), nib);
        end

        // Saturation: preload the counter just below the top, then beacons.
        rxCycle(1'b0, 1'b0, 4'd0);
        force dut.u_det.beaconCnt_q = 16'hFFFE;
        mCnt = 65534;
        rxCycle(1'b0, 1'b0, 4'd0);
        release dut.u_det.beaconCnt_q;
        rxCycle(1'b0, 1'b0, 4'd0);
        for (int p = 0; p < 3; p++) begin
            repeat (2) rxCycle(1'b0, 1'b1, 4'b0010);
            rxCycle(1'b0, 1'b0, 4'd0);
        end
        checkOutput("beacon_sat", beacon_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
